// File: rtl/sobel_gradient.sv
// -----------------------------------------------------------------------------
// sobel_gradient
//   Streaming 3x3 Sobel operator. Pixels arrive in raster order, one per cycle
//   with enb=1. Two line buffers supply the rows above the current pixel, and a
//   3x3 window register holds the neighbourhood. For every interior pixel the
//   block emits a saturated |Gx|+|Gy| magnitude and a direction quantised to
//   0/45/90/135 degrees.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   enb        pixel-valid; pix_in is accepted on every rising edge with enb=1
//   pix_in     smoothed input pixel (PIX_W bits), row 0 col 0 first
//   grad_mag   min(|Gx|+|Gy|, 2^PIX_W-1)
//   grad_dir   0=0deg, 1=45deg, 2=90deg, 3=135deg
//   out_valid  one-cycle pulse per interior-pixel result
//   frame_done one-cycle pulse together with the last out_valid of a frame
// -----------------------------------------------------------------------------
module sobel_gradient #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] grad_mag,
    output logic [1:0]       grad_dir,
    output logic             out_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int GW = PIX_W + 3;   // signed gradient, +/-4*(2^PIX_W-1)
    localparam int SW = PIX_W + 4;   // |Gx|+|Gy|
    localparam int DW = PIX_W + 6;   // headroom for 5*|G| in the direction test

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [PIX_W-1:0]      lb1 [IMG_WIDTH];   // one row up
    logic [PIX_W-1:0]      lb2 [IMG_WIDTH];   // two rows up
    logic [PIX_W-1:0]      up1;
    logic [PIX_W-1:0]      up2;
    logic [PIX_W-1:0]      win_p0 [3][3];
    logic                  vld_p0;
    logic                  last_p0;
    logic signed [GW-1:0]  gx;
    logic signed [GW-1:0]  gy;
    logic [GW-1:0]         ax;
    logic [GW-1:0]         ay;
    logic [SW-1:0]         sum;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] g);
        logic signed [GW-1:0] n;
        n = -g;
        return g[GW-1] ? $unsigned(n) : $unsigned(g);
    endfunction

    function automatic logic [PIX_W-1:0] sat_mag(input logic [SW-1:0] s);
        if (s > SW'({PIX_W{1'b1}}))
            return {PIX_W{1'b1}};
        else
            return s[PIX_W-1:0];
    endfunction

    // Ratio tests replace atan: tan(22.5)~0.4 and tan(67.5)~2.5.
    // A zero component is only reachable through the first two tests, so the
    // sign comparison never sees a zero operand.
    function automatic logic [1:0] quant_dir(input logic [GW-1:0] a_x,
                                             input logic [GW-1:0] a_y,
                                             input logic          s_x,
                                             input logic          s_y);
        logic [DW-1:0] xe;
        logic [DW-1:0] ye;
        xe = DW'(a_x);
        ye = DW'(a_y);
        if (((ye << 2) + ye) <= (xe << 1))
            return 2'd0;
        else if ((ye << 1) >= ((xe << 2) + xe))
            return 2'd2;
        else if (s_x == s_y)
            return 2'd1;
        else
            return 2'd3;
    endfunction

    // ---- stage p0: counters, line buffers, window --------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col     <= '0;
            row     <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            // Requiring col>=2 keeps the window within a single line.
            vld_p0  <= enb && (row >= RW'(2)) && (col >= CW'(2));
            last_p0 <= enb && (row == ROW_LAST) && (col == COL_LAST);
            if (enb) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffers are refilled by rows 0 and 1 before any output, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        if (enb) begin
            lb1[col] <= pix_in;
            lb2[col] <= lb1[col];
        end
    end

    assign up1 = lb1[col];
    assign up2 = lb2[col];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win_p0[i][j] <= '0;
        end else if (enb) begin
            for (int i = 0; i < 3; i++) begin
                win_p0[i][0] <= win_p0[i][1];
                win_p0[i][1] <= win_p0[i][2];
            end
            win_p0[0][2] <= up2;
            win_p0[1][2] <= up1;
            win_p0[2][2] <= pix_in;
        end
    end

    always_comb begin
        gx  = (ext(win_p0[0][2]) + ext(win_p0[1][2]) + ext(win_p0[1][2]) + ext(win_p0[2][2]))
            - (ext(win_p0[0][0]) + ext(win_p0[1][0]) + ext(win_p0[1][0]) + ext(win_p0[2][0]));
        gy  = (ext(win_p0[2][0]) + ext(win_p0[2][1]) + ext(win_p0[2][1]) + ext(win_p0[2][2]))
            - (ext(win_p0[0][0]) + ext(win_p0[0][1]) + ext(win_p0[0][1]) + ext(win_p0[0][2]));
        ax  = abs_g(gx);
        ay  = abs_g(gy);
        sum = SW'(ax) + SW'(ay);
    end

    // ---- stage p1: registered result, never stalls -------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            grad_mag   <= '0;
            grad_dir   <= '0;
        end else begin
            out_valid  <= vld_p0;
            frame_done <= last_p0;
            if (vld_p0) begin
                grad_mag <= sat_mag(sum);
                grad_dir <= quant_dir(ax, ay, gx[GW-1], gy[GW-1]);
            end
        end
    end

endmodule
